// File: rtl/remain_count_gen.sv
// Alarm remaining-count source: counts a BCD digit down from START_COUNT once per TICK_DIV cycles.
// Optional snooze support is enabled by defining REMAIN_SNOOZE_EN.
//
// state | meaning
// IDLE  | no alarm; digit 0, prescaler held at 0
// RUN   | alarm active; digit steps down at each prescaler terminal count
// DONE  | one-cycle EXPIRED pulse after natural completion
module remain_count_gen #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int START_COUNT = 9,
    parameter int SNOOZE_MAX  = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TRIG,
    input  logic       STOP,
    input  logic       SNOOZE,
    output logic [3:0] digit,
    output logic       ALARM,
    output logic       EXPIRED
);

    localparam int              PW          = $clog2(TICK_DIV);
    localparam logic [PW-1:0]   PS_LAST     = PW'(TICK_DIV - 1);
    localparam logic [3:0]      START_DIGIT = 4'(START_COUNT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic            tick;
    logic            snooze_ok;

    assign tick = (prescaler == PS_LAST);

`ifdef REMAIN_SNOOZE_EN
    localparam int            SW       = (SNOOZE_MAX < 1) ? 1 : $clog2(SNOOZE_MAX + 1);
    localparam logic [SW-1:0] SN_LIMIT = SW'(SNOOZE_MAX);

    logic [SW-1:0] snooze_cnt;

    assign snooze_ok = SNOOZE && (snooze_cnt < SN_LIMIT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            snooze_cnt <= '0;
        end else if (state == IDLE && TRIG && !STOP) begin
            snooze_cnt <= '0;
        end else if (state == RUN && !STOP && snooze_ok) begin
            snooze_cnt <= snooze_cnt + 1'b1;
        end
    end
`else
    localparam int snooze_max_unused = SNOOZE_MAX;
    logic snooze_unused;

    assign snooze_unused = SNOOZE;
    assign snooze_ok     = 1'b0;
`endif

    // Priority inside RUN: STOP, then snooze reload, then the terminal tick.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            digit     <= '0;
            ALARM     <= 1'b0;
            EXPIRED   <= 1'b0;
            prescaler <= '0;
        end else begin
            EXPIRED <= 1'b0;
            unique case (state)
                IDLE: begin
                    prescaler <= '0;
                    digit     <= '0;
                    ALARM     <= 1'b0;
                    if (TRIG && !STOP) begin
                        state <= RUN;
                        digit <= START_DIGIT;
                        ALARM <= 1'b1;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        state     <= IDLE;
                        digit     <= '0;
                        ALARM     <= 1'b0;
                        prescaler <= '0;
                    end else if (snooze_ok) begin
                        digit     <= START_DIGIT;
                        prescaler <= '0;
                    end else if (tick) begin
                        prescaler <= '0;
                        if (digit == 4'd0) begin
                            state   <= DONE;
                            ALARM   <= 1'b0;
                            EXPIRED <= 1'b1;
                        end else begin
                            digit <= digit - 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    digit     <= '0;
                    ALARM     <= 1'b0;
                    prescaler <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remain_count_gen.sv
// Self-checking bench for remain_count_gen (TICK_DIV=4, START_COUNT=3, plus a START_COUNT=0 instance).
module tb_remain_count_gen;

    localparam int D       = 4;
    localparam int S       = 3;
    localparam int SMAX    = 3;
    localparam int RUN_LEN = (S + 1) * D;
`ifdef REMAIN_SNOOZE_EN
    localparam bit SN_EN = 1'b1;
`else
    localparam bit SN_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       TRIG = 1'b0, STOP = 1'b0, SNOOZE = 1'b0;
    logic       TRIG0 = 1'b0;
    logic [3:0] digit, digit0;
    logic       ALARM, EXPIRED, ALARM0, EXPIRED0;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed cycles since (re)start rather than any state encoding.
    bit m_run, m_exp;
    int m_k, m_sn;

    always #5 CLK = ~CLK;

    remain_count_gen #(.TICK_DIV(D), .START_COUNT(S), .SNOOZE_MAX(SMAX)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG), .STOP(STOP), .SNOOZE(SNOOZE),
        .digit(digit), .ALARM(ALARM), .EXPIRED(EXPIRED)
    );

    remain_count_gen #(.TICK_DIV(D), .START_COUNT(0), .SNOOZE_MAX(SMAX)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .TRIG(TRIG0), .STOP(1'b0), .SNOOZE(1'b0),
        .digit(digit0), .ALARM(ALARM0), .EXPIRED(EXPIRED0)
    );

    function automatic void model_reset();
        m_run = 1'b0; m_exp = 1'b0; m_k = 0; m_sn = 0;
    endfunction

    function automatic void model_edge(input logic t, input logic s, input logic z);
        if (m_run) begin
            m_exp = 1'b0;
            if (s) m_run = 1'b0;
            else if (SN_EN && z && m_sn < SMAX) begin m_k = 1; m_sn++; end
            else if (m_k == RUN_LEN) begin m_run = 1'b0; m_exp = 1'b1; end
            else m_k++;
        end else begin
            if (!m_exp && t && !s) begin m_run = 1'b1; m_k = 1; m_sn = 0; end
            m_exp = 1'b0;
        end
    endfunction

    function automatic logic [5:0] model_out();
        int d;
        d = m_run ? S - (m_k - 1) / D : 0;
        return {m_run, m_exp, 4'(d)};
    endfunction

    // Expected {ALARM, EXPIRED, digit} n cycles after a lone TRIG at cycle 0.
    function automatic logic [5:0] nat_exp(input int n);
        if (n >= 1 && n <= RUN_LEN) return {2'b10, 4'(S - (n - 1) / D)};
        if (n == RUN_LEN + 1)       return {2'b01, 4'd0};
        return 6'd0;
    endfunction

    task automatic step(input logic t, input logic s, input logic z);
        TRIG = t; STOP = s; SNOOZE = z;
        @(posedge CLK);
        model_edge(t, s, z);
        #1;
        TRIG = 1'b0; STOP = 1'b0; SNOOZE = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        model_reset();
        #12;
        checks++; if (digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%0d want=0", digit); end
        checks++; if (ALARM !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b want=0", ALARM); end
        checks++; if (EXPIRED !== 1'b0) begin errors++; $display("FAIL reset_expired got=%b want=0", EXPIRED); end
        RST_N = 1'b1;
    endtask

    task automatic test_natural();
        for (int c = 0; c < RUN_LEN + 2; c++) begin
            step(c == 0, 1'b0, 1'b0);
            checks++;
            if ({ALARM, EXPIRED, digit} !== nat_exp(c + 1)) begin
                errors++;
                $display("FAIL natural cyc=%0d got=%b want=%b", c + 1, {ALARM, EXPIRED, digit}, nat_exp(c + 1));
            end
        end
    endtask

    task automatic test_stop();
        for (int c = 0; c < 10; c++) begin
            step(c == 0, c == 7, 1'b0);
            if (c + 1 == 8) begin
                checks++;
                if ({ALARM, digit} !== 5'd0) begin errors++; $display("FAIL stop_mid got=%b want=00000", {ALARM, digit}); end
            end
            checks++;
            if (EXPIRED !== 1'b0) begin errors++; $display("FAIL stop_mid_expired cyc=%0d got=%b want=0", c + 1, EXPIRED); end
        end
        for (int c = 0; c < RUN_LEN + 3; c++) begin
            step(c == 0, c == RUN_LEN, 1'b0);
            checks++;
            if (EXPIRED !== 1'b0) begin errors++; $display("FAIL stop_last_expired cyc=%0d got=%b want=0", c + 1, EXPIRED); end
        end
        checks++;
        if (ALARM !== 1'b0) begin errors++; $display("FAIL stop_last_alarm got=%b want=0", ALARM); end
    endtask

    task automatic test_ignored();
        for (int c = 0; c < RUN_LEN + 2; c++) begin
            step(c == 0 || c == 6 || c == RUN_LEN + 1, 1'b0, 1'b0);
            checks++;
            if ({ALARM, EXPIRED, digit} !== nat_exp(c + 1)) begin
                errors++;
                $display("FAIL retrig cyc=%0d got=%b want=%b", c + 1, {ALARM, EXPIRED, digit}, nat_exp(c + 1));
            end
        end
        step(1'b1, 1'b1, 1'b0);
        checks++;
        if (ALARM !== 1'b0) begin errors++; $display("FAIL trig_stop_idle got=%b want=0", ALARM); end
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (ALARM !== 1'b0) begin errors++; $display("FAIL trig_stop_idle2 got=%b want=0", ALARM); end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 10; c++) step(c == 0, 1'b0, 1'b0);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({ALARM, EXPIRED, digit} !== 6'd0) begin
            errors++; $display("FAIL async_reset got=%b want=000000", {ALARM, EXPIRED, digit});
        end
        @(posedge CLK);
        #1 RST_N = 1'b1;
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        checks++;
        if (ALARM !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b want=0", ALARM); end
        for (int c = 0; c < RUN_LEN + 2; c++) begin
            step(c == 0, 1'b0, 1'b0);
            checks++;
            if ({ALARM, EXPIRED, digit} !== nat_exp(c + 1)) begin
                errors++;
                $display("FAIL restart cyc=%0d got=%b want=%b", c + 1, {ALARM, EXPIRED, digit}, nat_exp(c + 1));
            end
        end
    endtask

    task automatic test_snooze();
        if (SN_EN) begin
            for (int c = 0; c < 50; c++) begin
                step(c == 0, 1'b0, c == 10 || c == 20 || c == 30 || c == 40);
                checks++;
                if ({ALARM, EXPIRED, digit} !== model_out()) begin
                    errors++;
                    $display("FAIL snooze_seq cyc=%0d got=%b want=%b", c + 1, {ALARM, EXPIRED, digit}, model_out());
                end
                if (c + 1 == 11) begin
                    checks++;
                    if ({ALARM, digit} !== 5'b10011) begin errors++; $display("FAIL snooze_reload got=%b want=10011", {ALARM, digit}); end
                end
                if (c + 1 == 15) begin
                    checks++;
                    if (digit !== 4'd2) begin errors++; $display("FAIL snooze_step got=%0d want=2", digit); end
                end
                if (c + 1 == 41) begin
                    checks++;
                    if (digit !== 4'd1) begin errors++; $display("FAIL snooze_limit got=%0d want=1", digit); end
                end
                if (c + 1 == 47) begin
                    checks++;
                    if (EXPIRED !== 1'b1) begin errors++; $display("FAIL snooze_expire got=%b want=1", EXPIRED); end
                end
            end
        end else begin
            for (int c = 0; c < RUN_LEN + 2; c++) begin
                step(c == 0, 1'b0, c == 10);
                checks++;
                if ({ALARM, EXPIRED, digit} !== nat_exp(c + 1)) begin
                    errors++;
                    $display("FAIL snooze_off cyc=%0d got=%b want=%b", c + 1, {ALARM, EXPIRED, digit}, nat_exp(c + 1));
                end
            end
        end
    endtask

    task automatic test_start_zero();
        logic [5:0] want;
        TRIG0 = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        TRIG0 = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            want = (n <= D) ? 6'b100000 : (n == D + 1) ? 6'b010000 : 6'b000000;
            checks++;
            if ({ALARM0, EXPIRED0, digit0} !== want) begin
                errors++; $display("FAIL start_zero cyc=%0d got=%b want=%b", n, {ALARM0, EXPIRED0, digit0}, want);
            end
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_random();
        logic t, s, z;
        for (int i = 0; i < 1500; i++) begin
            t = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 39) == 0);
            z = ($urandom_range(0, 19) == 0);
            step(t, s, z);
            checks++;
            if ({ALARM, EXPIRED, digit} !== model_out()) begin
                errors++;
                $display("FAIL random i=%0d got=%b want=%b", i, {ALARM, EXPIRED, digit}, model_out());
            end
        end
    endtask

    initial begin
        test_reset();
        test_natural();
        test_stop();
        test_ignored();
        test_async_reset();
        test_snooze();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        test_start_zero();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
